// File: rtl/updown_cntr.sv
`default_nettype none
// ============================================================================
//  Module   : updown_cntr
//  Brief    : Parametrised synchronous up/down counter with programmable
//             modulus, parallel load, wrap/saturate mode, boundary event
//             pulse and sticky overflow flag.
//             Optional macro UPDOWN_CNTR_GRAY_EN adds a registered Gray-coded
//             copy of the count (count_gray).
//  Revision : 1.0 - initial release
// ============================================================================
module updown_cntr #(
    parameter int     WIDTH = 4,
    parameter longint MOD   = 16,
    parameter longint INIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             evt,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min
`ifdef UPDOWN_CNTR_GRAY_EN
    ,
    output logic [WIDTH-1:0] count_gray
`endif
);

    // Terminal value is kept one bit wider so MOD = 2^WIDTH compares cleanly.
    localparam logic [WIDTH:0]   c_MAX_EXT = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] c_INIT    = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_evt;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next;
    logic             w_evt_next;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = ({1'b0, r_count} == c_MAX_EXT);
    assign w_at_min = (r_count == '0);

    always_comb begin
        w_next     = r_count;
        w_evt_next = 1'b0;
        if (load) begin
            w_next = ({1'b0, load_val} > c_MAX_EXT) ? c_MAX : load_val;
        end else if (en) begin
            if (up) begin
                if (w_at_max) begin
                    w_evt_next = 1'b1;
                    if (!sat) begin
                        w_next = '0;
                    end
                end else begin
                    w_next = r_count + c_ONE;
                end
            end else begin
                if (w_at_min) begin
                    w_evt_next = 1'b1;
                    if (!sat) begin
                        w_next = c_MAX;
                    end
                end else begin
                    w_next = r_count - c_ONE;
                end
            end
        end
    end

    // A new event outranks a coincident clear of the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= c_INIT;
            r_evt   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_evt   <= w_evt_next;
            r_ovf   <= w_evt_next | (r_ovf & ~ovf_clr);
        end
    end

    assign count  = r_count;
    assign evt    = r_evt;
    assign ovf    = r_ovf;
    assign at_max = w_at_max;
    assign at_min = w_at_min;

`ifdef UPDOWN_CNTR_GRAY_EN
    localparam logic [WIDTH-1:0] c_INIT_GRAY = c_INIT ^ (c_INIT >> 1);

    logic [WIDTH-1:0] r_count_gray;

    // Encoded from the next value so the Gray copy tracks count with no lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_gray <= c_INIT_GRAY;
        end else begin
            r_count_gray <= w_next ^ (w_next >> 1);
        end
    end

    assign count_gray = r_count_gray;
`endif

endmodule
`default_nettype wire
